// File: rtl/seg_dyn_scan.sv
// seg_dyn_scan
//   Turns a 20-bit unsigned magnitude into a six-digit multiplexed 7-segment scan
//   for a common-anode display fed through an HC595 shifter. A sequential
//   double-dabble converter produces BCD. The scan then applies leading-zero
//   blanking, an optional minus sign and per-digit decimal points.
//
// Ports
//   clk     system clock, all logic on posedge
//   rst     synchronous active-high reset
//   data    magnitude to display (clamped to 999999, or 99999 when sign=1)
//   point   point[i]=1 lights the decimal point of digit i (digit 0 = rightmost)
//   sign    1 = leading minus sign
//   seg_en  1 = display on, 0 = all digits blank
//   sel     one-hot digit select, active high
//   seg     segments, active low; seg[7]=dp, seg[6:0]=g..a
//
// Converter states
//   state | meaning
//   IDLE  | compare input against last converted value, start on change/force
//   SHIFT | 20 add-3/shift-left iterations
//   DONE  | publish accumulator to display BCD register
module seg_dyn_scan #(
  parameter int SCAN_CNT_MAX = 49_999,
  parameter int BIN_W        = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] data,
  input  logic [5:0]       point,
  input  logic             sign,
  input  logic             seg_en,
  output logic [5:0]       sel,
  output logic [7:0]       seg
);

  localparam int CNT_W = (SCAN_CNT_MAX > 0) ? $clog2(SCAN_CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT_MAX);
  localparam logic [BIN_W-1:0] MAX_POS  = BIN_W'(999_999);
  localparam logic [BIN_W-1:0] MAX_NEG  = BIN_W'(99_999);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [6:0] GLYPH_MINUS = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  logic [1:0]       state;
  logic             force_conv;
  logic [4:0]       shift_cnt;
  logic [BIN_W-1:0] bin_sr;
  logic [23:0]      bcd_acc;
  logic [23:0]      bcd_adj;
  logic [BIN_W-1:0] last_mag;
  logic             last_sign;
  logic [23:0]      bcd_disp;
  logic             disp_sign;

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       idx;

  logic [BIN_W-1:0] mag;
  logic [BIN_W-1:0] mag_lim;
  logic [2:0]       high_digit;
  logic [3:0]       cur_nib;
  logic [6:0]       cur_glyph;

  // Clamp so the minus sign always has a free digit to land in
  always_comb begin
    mag_lim = sign ? MAX_NEG : MAX_POS;
    mag     = (data > mag_lim) ? mag_lim : data;
  end

  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < 6; i++) begin
      if (bcd_acc[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_acc[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      force_conv <= 1'b1;
      shift_cnt  <= '0;
      bin_sr     <= '0;
      bcd_acc    <= '0;
      last_mag   <= '0;
      last_sign  <= 1'b0;
      bcd_disp   <= '0;
      disp_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (force_conv || (mag != last_mag) || (sign != last_sign)) begin
            force_conv <= 1'b0;
            bin_sr     <= mag;
            bcd_acc    <= '0;
            last_mag   <= mag;
            last_sign  <= sign;
            shift_cnt  <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_acc, bin_sr} <= {bcd_adj[22:0], bin_sr, 1'b0};
          shift_cnt         <= shift_cnt + 5'd1;
          if (shift_cnt == 5'(BIN_W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Sign travels with its digits so the minus never pairs with a stale value
          bcd_disp  <= bcd_acc;
          disp_sign <= last_sign;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Highest non-zero digit; stays 0 for a zero value so digit 0 still shows "0"
  always_comb begin
    high_digit = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (bcd_disp[i*4 +: 4] != 4'd0) begin
        high_digit = 3'(i);
      end
    end
  end

  always_comb begin
    cur_nib = bcd_disp[{idx, 2'b00} +: 4];
    case (cur_nib)
      4'd0:    cur_glyph = 7'h40;
      4'd1:    cur_glyph = 7'h79;
      4'd2:    cur_glyph = 7'h24;
      4'd3:    cur_glyph = 7'h30;
      4'd4:    cur_glyph = 7'h19;
      4'd5:    cur_glyph = 7'h12;
      4'd6:    cur_glyph = 7'h02;
      4'd7:    cur_glyph = 7'h78;
      4'd8:    cur_glyph = 7'h00;
      4'd9:    cur_glyph = 7'h10;
      default: cur_glyph = GLYPH_BLANK;
    endcase
    if (idx > high_digit) begin
      cur_glyph = (disp_sign && (idx == high_digit + 3'd1)) ? GLYPH_MINUS : GLYPH_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !seg_en) begin
      sel <= 6'b0;
      seg <= 8'hFF;
    end else begin
      sel <= 6'b1 << idx;
      seg <= {~point[idx], cur_glyph};
    end
  end

endmodule

// File: tb/tb_seg_dyn_scan.sv
// tb_seg_dyn_scan
//   Directed bench for seg_dyn_scan with a 10-cycle digit dwell. Each scenario
//   task drives the inputs and then compares the scanned frame against
//   glyph values worked out by hand.
module tb_seg_dyn_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame [6];
  bit         seen  [6];

  seg_dyn_scan #(.SCAN_CNT_MAX(9), .BIN_W(20)) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .point  (point),
    .sign   (sign),
    .seg_en (seg_en),
    .sel    (sel),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rotl(input logic [5:0] x, input int k);
    logic [11:0] t;
    t = {x, x} << k;
    return t[11:6];
  endfunction

  // Records the last seg value seen under each one-hot select
  task automatic capture(input int cycles);
    for (int d = 0; d < 6; d++) begin
      seen[d]  = 1'b0;
      frame[d] = 8'h00;
    end
    repeat (cycles) begin
      @(negedge clk);
      for (int d = 0; d < 6; d++) begin
        if (sel == rotl(6'b000001, d)) begin
          frame[d] = seg;
          seen[d]  = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data = '0; point = '0; sign = 1'b0; seg_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sel !== 6'h00) begin
      errors++; $display("FAIL reset_sel got %h want 00", sel);
    end
    checks++;
    if (seg !== 8'hFF) begin
      errors++; $display("FAIL reset_seg got %h want FF", seg);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_f [6];
    exp_f = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    data = 20'd123456; sign = 1'b0; point = '0; seg_en = 1'b1;
    repeat (30) @(negedge clk);
    capture(70);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (!seen[d] || frame[d] !== exp_f[d]) begin
        errors++; $display("FAIL basic_digit%0d got %h seen %0d want %h", d, frame[d], seen[d], exp_f[d]);
      end
    end
  endtask

  task automatic test_blank_sign();
    logic [7:0] exp_a [6];
    logic [7:0] exp_b [6];
    exp_a = '{8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_b = '{8'hA4, 8'h99, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
    data = 20'd42; sign = 1'b0;
    repeat (30) @(negedge clk);
    capture(70);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (!seen[d] || frame[d] !== exp_a[d]) begin
        errors++; $display("FAIL blank42_digit%0d got %h want %h", d, frame[d], exp_a[d]);
      end
    end
    sign = 1'b1;
    repeat (30) @(negedge clk);
    capture(70);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (!seen[d] || frame[d] !== exp_b[d]) begin
        errors++; $display("FAIL minus42_digit%0d got %h want %h", d, frame[d], exp_b[d]);
      end
    end
  endtask

  task automatic test_zero_and_max();
    logic [7:0] exp_z [6];
    logic [7:0] exp_m [6];
    exp_z = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_m = '{8'h90, 8'h90, 8'h10, 8'h90, 8'h90, 8'h90};
    data = 20'd0; sign = 1'b0; point = '0;
    repeat (30) @(negedge clk);
    capture(70);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (!seen[d] || frame[d] !== exp_z[d]) begin
        errors++; $display("FAIL zero_digit%0d got %h want %h", d, frame[d], exp_z[d]);
      end
    end
    data = 20'd1048575; point = 6'b000100;
    repeat (30) @(negedge clk);
    capture(70);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (!seen[d] || frame[d] !== exp_m[d]) begin
        errors++; $display("FAIL clamp_pos_digit%0d got %h want %h", d, frame[d], exp_m[d]);
      end
    end
    point = '0;
  endtask

  task automatic test_neg_clamp();
    logic [7:0] exp_n [6];
    exp_n = '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'hBF};
    data = 20'd123456; sign = 1'b1;
    repeat (30) @(negedge clk);
    capture(70);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (!seen[d] || frame[d] !== exp_n[d]) begin
        errors++; $display("FAIL clamp_neg_digit%0d got %h want %h", d, frame[d], exp_n[d]);
      end
    end
    sign = 1'b0;
  endtask

  // Digit 0 may only step forward through 9 (old), 7, 8; nothing else may appear
  task automatic test_mid_shift();
    int  phase;
    bit  bad;
    phase = 0; bad = 1'b0;
    data = 20'd7;
    repeat (5) @(negedge clk);
    data = 20'd8;
    repeat (150) begin
      @(negedge clk);
      if (sel == 6'b000001) begin
        case (seg)
          8'h90: if (phase > 0) bad = 1'b1;
          8'hF8: if (phase > 1) bad = 1'b1; else phase = 1;
          8'h80: phase = 2;
          default: bad = 1'b1;
        endcase
      end
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL midshift_sequence got unexpected digit0 value want only 90/F8/80 in order");
    end
    checks++;
    if (phase != 2) begin
      errors++; $display("FAIL midshift_final got phase %0d want 2 (digit0=80)", phase);
    end
  endtask

  task automatic test_enable();
    logic [5:0] prev;
    logic [5:0] x;
    int         waited;
    prev = sel; waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while ((sel == prev || sel == 6'h00) && waited < 25);
    checks++;
    if (waited >= 25) begin
      errors++; $display("FAIL enable_sync got no sel change in %0d cycles want change", waited);
    end
    x = sel;
    @(negedge clk);
    @(negedge clk);
    seg_en = 1'b0;
    @(negedge clk);
    checks++;
    if (sel !== 6'h00 || seg !== 8'hFF) begin
      errors++; $display("FAIL enable_off got sel %h seg %h want 00 FF", sel, seg);
    end
    repeat (24) @(negedge clk);
    seg_en = 1'b1;
    @(negedge clk);
    checks++;
    if (sel !== rotl(x, 2)) begin
      errors++; $display("FAIL enable_resume got sel %h want %h", sel, rotl(x, 2));
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sel !== rotl(x, 3)) begin
      errors++; $display("FAIL enable_advance got sel %h want %h", sel, rotl(x, 3));
    end
  endtask

  task automatic test_reset_mid();
    data = 20'd555555; sign = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sel !== 6'h00 || seg !== 8'hFF) begin
      errors++; $display("FAIL midrst got sel %h seg %h want 00 FF", sel, seg);
    end
    rst = 1'b0;
    repeat (83) @(negedge clk);
    capture(70);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (!seen[d] || frame[d] !== 8'h92) begin
        errors++; $display("FAIL midrst_digit%0d got %h want 92", d, frame[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank_sign();
    test_zero_and_max();
    test_neg_clamp();
    test_mid_shift();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
